// File: rtl/sdram_arbiter_n_if.sv
// Bridge-side bus of the SDRAM arbiter: one outstanding transaction at a time.
// The arbiter drives the request half (master); the SDRAM bridge answers with
// acknowledge and read data (slave).
interface sdram_arbiter_n_if #(
    parameter int ADDR_W = 22,
    parameter int DATA_W = 128,
    parameter int BE_W   = 16
);
    logic [ADDR_W-1:0] bridge_address;
    logic [BE_W-1:0]   bridge_byte_enable;
    logic              bridge_read;
    logic              bridge_write;
    logic [DATA_W-1:0] bridge_write_data;
    logic              bridge_acknowledge;
    logic [DATA_W-1:0] bridge_read_data;

    modport master (
        output bridge_address,
        output bridge_byte_enable,
        output bridge_read,
        output bridge_write,
        output bridge_write_data,
        input  bridge_acknowledge,
        input  bridge_read_data
    );

    modport slave (
        input  bridge_address,
        input  bridge_byte_enable,
        input  bridge_read,
        input  bridge_write,
        input  bridge_write_data,
        output bridge_acknowledge,
        output bridge_read_data
    );
endinterface

// File: rtl/sdram_arbiter_n.sv
// N-client arbiter in front of the single 128-bit SDRAM bridge.
// Clients 0..PRIO_CLIENTS-1 are fixed priority (lowest index wins), the rest
// share a round-robin group. One bridge transaction runs at a time; the winner
// gets a one-cycle cl_ac with the registered read data.
// Optional feature: define SDRAM_ARB_TIMEOUT_EN to add a watchdog that aborts
// an unacknowledged transaction after TIMEOUT_CYCLES and flags it on cl_err.
//
// state | meaning
// IDLE  | no transaction; arbitrate requests sampled this cycle
// ISSUE | bridge strobe held with stable address/data, waiting for ack
// DONE  | cl_ac pulse to the granted client, then back to IDLE
module sdram_arbiter_n #(
    parameter int N_CLIENTS      = 8,
    parameter int PRIO_CLIENTS   = 2,
    parameter int ADDR_W         = 22,
    parameter int DATA_W         = 128,
    parameter int BE_W           = 16,
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [N_CLIENTS-1:0]        cl_rd,
    input  logic [N_CLIENTS-1:0]        cl_wr,
    input  logic [N_CLIENTS*ADDR_W-1:0] cl_addr,
    input  logic [N_CLIENTS*DATA_W-1:0] cl_wrdata,
    input  logic [N_CLIENTS*BE_W-1:0]   cl_be,
    output logic [N_CLIENTS-1:0]        cl_wait,
    output logic [N_CLIENTS-1:0]        cl_ac,
    output logic                        cl_err,
    output logic [DATA_W-1:0]           rddata,
    output logic [3:0]                  grant_id,
    output logic                        busy,
    sdram_arbiter_n_if.master           bus
);

    localparam int N_RR = N_CLIENTS - PRIO_CLIENTS;
    localparam logic [4:0] RR_BASE = 5'(PRIO_CLIENTS);

    if (N_CLIENTS < 2 || N_CLIENTS > 16 || PRIO_CLIENTS < 0 ||
        PRIO_CLIENTS > N_CLIENTS || TIMEOUT_CYCLES < 1) begin : g_bad_params
        $error("sdram_arbiter_n: parameter out of range");
    end

    typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_t;

    state_t               state;
    logic [4:0]           rr_ptr;
    logic [N_CLIENTS-1:0] req;
    logic [N_CLIENTS-1:0] grant_onehot;

    logic                 prio_hit;
    logic [3:0]           prio_idx;
    logic                 rr_hit;
    logic [3:0]           rr_idx;
    logic                 win_valid;
    logic                 win_rr;
    logic [3:0]           win_idx;
    logic [4:0]           win_inc;
    logic [4:0]           rr_next;
    logic [ADDR_W-1:0]    win_addr;
    logic [DATA_W-1:0]    win_data;
    logic [BE_W-1:0]      win_be;
    logic                 win_wr;

`ifdef SDRAM_ARB_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [WD_W-1:0] wdog;
`else
    assign cl_err = 1'b0;
`endif

    assign req          = cl_rd | cl_wr;
    assign cl_wait      = req & ~cl_ac;
    assign busy         = (state != IDLE);
    assign grant_onehot = {{(N_CLIENTS-1){1'b0}}, 1'b1} << grant_id;

    // Winner: lowest-index priority request, else first round-robin request from rr_ptr.
    always_comb begin
        int c;
        c        = 0;
        prio_hit = 1'b0;
        prio_idx = '0;
        rr_hit   = 1'b0;
        rr_idx   = '0;
        // Scanning downwards leaves the lowest index / nearest-to-pointer hit last.
        for (int i = PRIO_CLIENTS - 1; i >= 0; i--) begin
            if (req[i]) begin
                prio_hit = 1'b1;
                prio_idx = 4'(i);
            end
        end
        for (int k = N_RR - 1; k >= 0; k--) begin
            c = int'(rr_ptr) + k;
            if (c >= N_CLIENTS)
                c = c - N_RR;
            if (req[c]) begin
                rr_hit = 1'b1;
                rr_idx = 4'(c);
            end
        end
        win_valid = prio_hit | rr_hit;
        win_rr    = ~prio_hit & rr_hit;
        win_idx   = prio_hit ? prio_idx : rr_idx;
        win_inc   = {1'b0, win_idx} + 5'd1;
        rr_next   = (win_inc >= 5'(N_CLIENTS)) ? RR_BASE : win_inc;
        win_addr  = cl_addr[int'(win_idx)*ADDR_W +: ADDR_W];
        win_data  = cl_wrdata[int'(win_idx)*DATA_W +: DATA_W];
        win_be    = cl_be[int'(win_idx)*BE_W +: BE_W];
        // A client asserting both strobes gets a write; its read is dropped.
        win_wr    = cl_wr[win_idx];
    end

    // Transaction sequencer: latch the winner, hold the strobe until ack (or watchdog), pulse cl_ac.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state                  <= IDLE;
            rr_ptr                 <= RR_BASE;
            grant_id               <= '0;
            cl_ac                  <= '0;
            rddata                 <= '0;
            bus.bridge_address     <= '0;
            bus.bridge_byte_enable <= '0;
            bus.bridge_write_data  <= '0;
            bus.bridge_read        <= 1'b0;
            bus.bridge_write       <= 1'b0;
`ifdef SDRAM_ARB_TIMEOUT_EN
            cl_err                 <= 1'b0;
            wdog                   <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    cl_ac <= '0;
                    if (win_valid) begin
                        grant_id               <= win_idx;
                        bus.bridge_address     <= win_addr;
                        bus.bridge_byte_enable <= win_be;
                        bus.bridge_write_data  <= win_data;
                        bus.bridge_write       <= win_wr;
                        bus.bridge_read        <= ~win_wr;
                        if (win_rr)
                            rr_ptr <= rr_next;
`ifdef SDRAM_ARB_TIMEOUT_EN
                        wdog <= '0;
`endif
                        state <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (bus.bridge_acknowledge) begin
                        if (bus.bridge_read)
                            rddata <= bus.bridge_read_data;
                        bus.bridge_read  <= 1'b0;
                        bus.bridge_write <= 1'b0;
                        cl_ac            <= grant_onehot;
`ifdef SDRAM_ARB_TIMEOUT_EN
                        cl_err           <= 1'b0;
`endif
                        state            <= DONE;
                    end
`ifdef SDRAM_ARB_TIMEOUT_EN
                    else if (wdog == WD_W'(TIMEOUT_CYCLES - 1)) begin
                        bus.bridge_read  <= 1'b0;
                        bus.bridge_write <= 1'b0;
                        cl_ac            <= grant_onehot;
                        cl_err           <= 1'b1;
                        state            <= DONE;
                    end else begin
                        wdog <= wdog + 1'b1;
                    end
`endif
                end
                DONE: begin
                    cl_ac <= '0;
`ifdef SDRAM_ARB_TIMEOUT_EN
                    cl_err <= 1'b0;
`endif
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sdram_arbiter_n.sv
// Self-checking bench for sdram_arbiter_n: batches of client requests are
// queued against a reference arbitration model; a bridge responder acks with
// random latency/data and a monitor checks each strobe and each cl_ac.
module tb_sdram_arbiter_n;
    localparam int N    = 8;
    localparam int PRIO = 2;
    localparam int AW   = 22;
    localparam int DW   = 128;
    localparam int BW   = 16;
    localparam int TMO  = 15;
    localparam int N_RR = N - PRIO;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic [N-1:0]    cl_rd = '0;
    logic [N-1:0]    cl_wr = '0;
    logic [N*AW-1:0] cl_addr = '0;
    logic [N*DW-1:0] cl_wrdata = '0;
    logic [N*BW-1:0] cl_be = '0;
    logic [N-1:0]    cl_wait;
    logic [N-1:0]    cl_ac;
    logic            cl_err;
    logic [DW-1:0]   rddata;
    logic [3:0]      grant_id;
    logic            busy;

    sdram_arbiter_n_if #(.ADDR_W(AW), .DATA_W(DW), .BE_W(BW)) bus ();

    sdram_arbiter_n #(
        .N_CLIENTS(N), .PRIO_CLIENTS(PRIO), .ADDR_W(AW), .DATA_W(DW),
        .BE_W(BW), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk), .reset(reset),
        .cl_rd(cl_rd), .cl_wr(cl_wr), .cl_addr(cl_addr),
        .cl_wrdata(cl_wrdata), .cl_be(cl_be),
        .cl_wait(cl_wait), .cl_ac(cl_ac), .cl_err(cl_err),
        .rddata(rddata), .grant_id(grant_id), .busy(busy),
        .bus(bus)
    );

    always #10 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        int            id;
        bit            wr;
        logic [AW-1:0] addr;
        logic [BW-1:0] be;
        logic [DW-1:0] wdata;
        bit            tmo;
    } exp_t;

    typedef struct {
        int            cyc;
        logic [DW-1:0] data;
    } ack_t;

    exp_t          exp_q[$];
    ack_t          ack_q[$];
    logic [DW-1:0] exp_rd = '0;
    int            m_rr = PRIO;
    int            strobe_cyc = 0;
    bit            auto_ack = 1'b1;
    bit            tmo_mode = 1'b0;
    int            fixed_lat = -1;
    bit            use_fixed_data = 1'b0;
    logic [DW-1:0] fixed_data = '0;

    bit            t_rd[N];
    bit            t_wr[N];
    logic [AW-1:0] t_addr[N];
    logic [BW-1:0] t_be[N];
    logic [DW-1:0] t_wd[N];

    // Reference arbitration: priority list first, then rotation over the round-robin group.
    function automatic int pick(input logic [N-1:0] pend);
        for (int i = 0; i < PRIO; i++)
            if (pend[i]) return i;
        for (int k = 0; k < N_RR; k++) begin
            int c;
            c = PRIO + ((m_rr - PRIO + k) % N_RR);
            if (pend[c]) begin
                m_rr = PRIO + ((c - PRIO + 1) % N_RR);
                return c;
            end
        end
        return -1;
    endfunction

    task automatic set_client(input int i, input bit rd, input bit wr, input logic [AW-1:0] a,
                              input logic [BW-1:0] be, input logic [DW-1:0] d);
        t_rd[i] = rd; t_wr[i] = wr; t_addr[i] = a; t_be[i] = be; t_wd[i] = d;
    endtask

    task automatic rand_client(input int i);
        bit rd, wr;
        rd = 1'($urandom_range(0, 1));
        wr = 1'($urandom_range(0, 1));
        if (!rd && !wr) rd = 1'b1;
        set_client(i, rd, wr, AW'($urandom), BW'($urandom),
                   {$urandom, $urandom, $urandom, $urandom});
    endtask

    // Push the expected grant order for a batch, raise the requests, drop each on its cl_ac.
    task automatic run_batch(input logic [N-1:0] mask);
        logic [N-1:0] pend, outstanding, acked;
        int w, guard;
        exp_t e;
        pend = mask;
        while (pend != 0) begin
            w = pick(pend);
            e.id = w; e.wr = t_wr[w]; e.addr = t_addr[w]; e.be = t_be[w];
            e.wdata = t_wd[w]; e.tmo = tmo_mode;
            exp_q.push_back(e);
            pend[w] = 1'b0;
        end
        for (int i = 0; i < N; i++) begin
            if (mask[i]) begin
                cl_rd[i] = t_rd[i];
                cl_wr[i] = t_wr[i];
                cl_addr[i*AW +: AW]   = t_addr[i];
                cl_be[i*BW +: BW]     = t_be[i];
                cl_wrdata[i*DW +: DW] = t_wd[i];
            end
        end
        outstanding = mask;
        guard = 0;
        while (outstanding != 0 && guard < 500) begin
            @(negedge clk);
            acked = cl_ac & outstanding;
            @(posedge clk); #1;
            cl_rd = cl_rd & ~acked;
            cl_wr = cl_wr & ~acked;
            outstanding = outstanding & ~acked;
            guard++;
        end
        if (outstanding != 0) begin
            checks++; errors++;
            $display("FAIL batch_timeout: outstanding %0h expected 0", outstanding);
        end
    endtask

    // Bridge model: ack each strobe after a random (or forced) latency with fresh data.
    initial begin
        bus.bridge_acknowledge = 1'b0;
        bus.bridge_read_data   = '0;
        forever begin
            @(posedge clk); #1;
            if (auto_ack && !reset && (bus.bridge_read || bus.bridge_write)) begin
                int lat;
                ack_t a;
                lat = (fixed_lat >= 0) ? fixed_lat : int'($urandom_range(0, 4));
                repeat (lat) begin @(posedge clk); #1; end
                bus.bridge_read_data = use_fixed_data ? fixed_data
                                       : {$urandom, $urandom, $urandom, $urandom};
                bus.bridge_acknowledge = 1'b1;
                a.cyc = cyc; a.data = bus.bridge_read_data;
                ack_q.push_back(a);
                @(posedge clk); #1;
                bus.bridge_acknowledge = 1'b0;
            end
        end
    end

    // Monitor: check each new strobe against the queue head, pop and check on each cl_ac.
    initial begin
        bit   prev_stb, stb;
        exp_t e;
        ack_t a;
        prev_stb = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                prev_stb = 1'b0;
            end else begin
                stb = bus.bridge_read | bus.bridge_write;
                if (stb && !prev_stb) begin
                    if (exp_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_strobe: got strobe expected none");
                    end else begin
                        e = exp_q[0];
                        strobe_cyc = cyc;
                        chk("grant_id", grant_id, e.id);
                        chk("bridge_address", bus.bridge_address, e.addr);
                        chk("bridge_write", bus.bridge_write, e.wr);
                        chk("bridge_read", bus.bridge_read, !e.wr);
                        chk("busy", busy, 1);
                        if (e.wr) begin
                            chk("bridge_byte_enable", bus.bridge_byte_enable, e.be);
                            chk("bridge_write_data", bus.bridge_write_data, e.wdata);
                        end
                    end
                end
                prev_stb = stb;
                if (cl_ac != 0) begin
                    if (exp_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_ac: got %0h expected 0", cl_ac);
                    end else begin
                        e = exp_q.pop_front();
                        chk("cl_ac", cl_ac, N'(1) << e.id);
                        chk("cl_err", cl_err, e.tmo);
                        chk("cl_wait", cl_wait, (cl_rd | cl_wr) & ~(N'(1) << e.id));
                        if (e.tmo) begin
                            chk("timeout_latency", cyc - strobe_cyc, TMO);
                        end else if (ack_q.size() == 0) begin
                            checks++; errors++;
                            $display("FAIL ac_without_ack: got cl_ac %0h expected no ac", cl_ac);
                        end else begin
                            a = ack_q.pop_front();
                            chk("ack_to_ac_latency", cyc, a.cyc + 1);
                            if (!e.wr) exp_rd = a.data;
                        end
                        chk("rddata", rddata, exp_rd);
                    end
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    // Directed cases then randomized batches.
    initial begin
        logic [N-1:0] m;
        int           guard;
        bit           stray;

        repeat (3) @(posedge clk);
        #1;
        chk("reset_cl_ac", cl_ac, 0);
        chk("reset_cl_err", cl_err, 0);
        chk("reset_rddata", rddata, 0);
        chk("reset_grant_id", grant_id, 0);
        chk("reset_busy", busy, 0);
        chk("reset_strobes", {bus.bridge_read, bus.bridge_write}, 0);
        chk("reset_address", bus.bridge_address, 0);
        chk("reset_cl_wait", cl_wait, 0);
        reset = 1'b0;
        @(posedge clk); #1;

        // Single read, ack 4 cycles after the strobe with A5 data.
        fixed_lat = 4; use_fixed_data = 1'b1; fixed_data = {16{8'hA5}};
        set_client(5, 1'b1, 1'b0, 22'h12345, 16'hFFFF, '0);
        run_batch(N'(1) << 5);
        fixed_lat = -1; use_fixed_data = 1'b0;

        // Priority vs round-robin in the same cycle.
        rand_client(1); rand_client(3); rand_client(6);
        run_batch((N'(1) << 1) | (N'(1) << 3) | (N'(1) << 6));

        // Round-robin rotation over two rounds.
        for (int r = 0; r < 2; r++) begin
            rand_client(2); rand_client(4); rand_client(7);
            run_batch((N'(1) << 2) | (N'(1) << 4) | (N'(1) << 7));
        end

        // Read and write together becomes a write.
        set_client(0, 1'b1, 1'b1, AW'($urandom), 16'h00FF, 128'h1234);
        run_batch(N'(1));

        for (int b = 0; b < 40; b++) begin
            m = N'($urandom);
            if (m == 0) m = N'(1) << $urandom_range(0, N - 1);
            for (int i = 0; i < N; i++) rand_client(i);
            run_batch(m);
        end

        // Leave the rotation pointer away from its reset value.
        rand_client(4);
        run_batch(N'(1) << 4);

        // Reset in the middle of a transaction from client 3.
        auto_ack = 1'b0;
        set_client(3, 1'b1, 1'b0, AW'($urandom), BW'($urandom), '0);
        begin
            exp_t e;
            void'(pick(N'(1) << 3));
            e.id = 3; e.wr = 1'b0; e.addr = t_addr[3]; e.be = t_be[3]; e.wdata = '0; e.tmo = 1'b0;
            exp_q.push_back(e);
        end
        cl_rd[3] = 1'b1;
        cl_addr[3*AW +: AW] = t_addr[3];
        cl_be[3*BW +: BW] = t_be[3];
        guard = 0;
        while (!bus.bridge_read && guard < 20) begin
            @(posedge clk); #1;
            guard++;
        end
        chk("reset_test_strobe_seen", bus.bridge_read, 1);
        repeat (2) @(posedge clk);
        @(negedge clk); #5;
        reset = 1'b1;
        #1;
        chk("midreset_strobes", {bus.bridge_read, bus.bridge_write}, 0);
        chk("midreset_busy", busy, 0);
        chk("midreset_cl_ac", cl_ac, 0);
        chk("midreset_grant_id", grant_id, 0);
        chk("midreset_address", bus.bridge_address, 0);
        exp_q.delete(); ack_q.delete();
        m_rr = PRIO; exp_rd = '0;
        cl_rd = '0; cl_wr = '0;
        @(negedge clk); #5;
        reset = 1'b0;
        @(posedge clk); #1;
        bus.bridge_acknowledge = 1'b1;
        @(posedge clk); #1;
        bus.bridge_acknowledge = 1'b0;
        stray = 1'b0;
        repeat (3) begin
            @(negedge clk);
            stray = stray | (cl_ac != 0) | busy | bus.bridge_read | bus.bridge_write;
        end
        chk("stray_ack_ignored", stray, 0);
        auto_ack = 1'b1;
        @(posedge clk); #1;
        rand_client(2); rand_client(3); rand_client(6);
        run_batch((N'(1) << 2) | (N'(1) << 3) | (N'(1) << 6));

`ifdef SDRAM_ARB_TIMEOUT_EN
        auto_ack = 1'b0; tmo_mode = 1'b1;
        set_client(6, 1'b1, 1'b0, AW'($urandom), BW'($urandom), '0);
        run_batch(N'(1) << 6);
        auto_ack = 1'b1; tmo_mode = 1'b0;
        rand_client(1);
        run_batch(N'(1) << 1);
`endif

        repeat (3) @(posedge clk);
        chk("exp_queue_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
